// File: rtl/updown_step_ctrl.sv
// ---------------------------------------------------------------------------
// updown_step_ctrl
//
// Front-end controller for the mod-N up/down counter. It turns the raw UP and
// DOWN push-buttons into a direction level (ud) and a one-cycle step pulse
// that gates the counter's clock enable.
//
// Processing chain, per button:
//   raw -> 2-flop synchroniser -> debouncer -> shared press/hold FSM
//
// The FSM issues one step when a button becomes pressed. It auto-repeats
// after REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles while the
// button stays held. Pressing both buttons locks stepping out until both are
// released.
//
// Parameters (all must be >= 2):
//   DEBOUNCE_CYCLES : consecutive synchronised cycles an input must disagree
//                     with its debounced value before that value flips
//   REPEAT_DELAY    : cycles from the first step of a hold to the first repeat
//   REPEAT_PERIOD   : cycles between successive repeat steps
//
// Ports:
//   clk    in  : rising-edge clock
//   reset  in  : asynchronous, active-low reset
//   btn_up in  : raw UP button (asynchronous, active-high)
//   btn_dn in  : raw DOWN button (asynchronous, active-high)
//   ud     out : direction, 0 = up, 1 = down; keeps the last direction issued
//   step   out : registered one-cycle step pulse
//   held   out : high while a single button is being held (UP_HELD/DN_HELD)
// ---------------------------------------------------------------------------
module updown_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_dn,
  output logic ud,
  output logic step,
  output logic held
);

  // Timer is sized for the larger of the two reload values plus one spare
  // bit. It is reloaded on reaching zero, so it never wraps during a hold.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(RPT_MAX) + 1;
  localparam int DBC_W   = $clog2(DEBOUNCE_CYCLES) + 1;

  // A timer loaded with N-1 reaches zero N cycles later. The step is issued
  // on that edge, which gives exactly N cycles between steps.
  localparam logic [TMR_W-1:0] TMR_DELAY  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] TMR_PERIOD = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic [DBC_W-1:0] DBC_LAST   = DBC_W'(DEBOUNCE_CYCLES - 1);

  // Bit index of each button in the per-button vectors below.
  localparam int IDX_UP = 0;
  localparam int IDX_DN = 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_UP_HELD = 2'd1,
    S_DN_HELD = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Synchroniser and debouncer state (one bit / one counter per button)
  // -------------------------------------------------------------------------
  logic [1:0]       btn_raw;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       deb_q;
  logic [1:0]       deb_d;
  logic [DBC_W-1:0] dbc_q [2];
  logic [DBC_W-1:0] dbc_d [2];

  assign btn_raw = {btn_dn, btn_up};

  // -------------------------------------------------------------------------
  // FSM state
  // -------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [TMR_W-1:0] tmr_d;
  logic             ud_q;
  logic             ud_d;
  logic             step_q;
  logic             step_d;

  logic deb_up;
  logic deb_dn;
  logic own_btn;    // debounced button that owns the current hold
  logic other_btn;  // debounced opposite button

  assign deb_up = deb_q[IDX_UP];
  assign deb_dn = deb_q[IDX_DN];

  // In a HELD state, own/other select the holding and opposing buttons.
  // This lets both HELD states share one transition description.
  assign own_btn   = (state_q == S_DN_HELD) ? deb_dn : deb_up;
  assign other_btn = (state_q == S_DN_HELD) ? deb_up : deb_dn;

  // -------------------------------------------------------------------------
  // Debounce next-state.
  // The counter measures how long the synchronised input has disagreed with
  // the debounced value. Any agreement clears it, so a bounce shorter than
  // DEBOUNCE_CYCLES cycles can never flip the debounced value.
  // -------------------------------------------------------------------------
  always_comb begin
    deb_d    = deb_q;
    dbc_d[0] = '0;
    dbc_d[1] = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (dbc_q[i] == DBC_LAST) begin
          deb_d[i] = ~deb_q[i];
          dbc_d[i] = '0;
        end else begin
          dbc_d[i] = dbc_q[i] + DBC_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      dbc_q[0] <= '0;
      dbc_q[1] <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      dbc_q[0] <= dbc_d[0];
      dbc_q[1] <= dbc_d[1];
    end
  end

  // -------------------------------------------------------------------------
  // Press / hold FSM next-state and outputs.
  // Only the entry from IDLE writes ud, so ud holds its value through
  // lockout and release.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    ud_d    = ud_q;
    step_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (deb_up && deb_dn) begin
          state_d = S_LOCKOUT;
        end else if (deb_up) begin
          step_d  = 1'b1;
          ud_d    = 1'b0;
          tmr_d   = TMR_DELAY;
          state_d = S_UP_HELD;
        end else if (deb_dn) begin
          step_d  = 1'b1;
          ud_d    = 1'b1;
          tmr_d   = TMR_DELAY;
          state_d = S_DN_HELD;
        end
      end

      S_UP_HELD, S_DN_HELD: begin
        // A press of the opposite button wins over a release of the
        // holding button.
        if (other_btn) begin
          state_d = S_LOCKOUT;
          tmr_d   = '0;
        end else if (!own_btn) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == '0) begin
          step_d = 1'b1;
          tmr_d  = TMR_PERIOD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      S_LOCKOUT: begin
        tmr_d = '0;
        if (!deb_up && !deb_dn) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      ud_q    <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      ud_q    <= ud_d;
      step_q  <= step_d;
    end
  end

  assign ud   = ud_q;
  assign step = step_q;
  assign held = (state_q == S_UP_HELD) || (state_q == S_DN_HELD);

endmodule

// File: tb/tb_updown_step_ctrl.sv
// ---------------------------------------------------------------------------
// Self-checking bench for updown_step_ctrl.
//
// The directed scenarios check edge numbers taken from the block's timing
// rules: step at edge DEBOUNCE_CYCLES+3 and repeats REPEAT_DELAY and
// REPEAT_PERIOD apart. The random scenario compares every cycle against a
// behavioural model. That model debounces by looking at the last
// DEBOUNCE_CYCLES synchronised samples. It schedules repeats from the number
// of cycles elapsed since the previous step.
// ---------------------------------------------------------------------------
module tb_updown_step_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 16;
  localparam int RP  = 8;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DN   = 2;
  localparam int M_LOCK = 3;

  logic clk;
  logic reset;
  logic btn_up;
  logic btn_dn;
  logic ud;
  logic step;
  logic held;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model state
  int   m_mode;
  int   m_n;
  int   m_last;
  int   m_nrep;
  logic m_deb_up;
  logic m_deb_dn;
  logic m_ud;
  logic m_step;
  logic h_up[$];
  logic h_dn[$];

  updown_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .btn_up(btn_up),
    .btn_dn(btn_dn),
    .ud    (ud),
    .step  (step),
    .held  (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit hit, got %0d tests run, required completion", n_tests);
    $fatal(1, "watchdog expired");
  end

  // One clock: inputs set before the call are sampled on the rising edge,
  // and outputs are observed on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Leaves reset released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    reset  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_n      = 0;
    m_last   = 0;
    m_nrep   = 0;
    m_deb_up = 1'b0;
    m_deb_dn = 1'b0;
    m_ud     = 1'b0;
    m_step   = 1'b0;
    h_up.delete();
    h_dn.delete();
    for (int k = 0; k <= DEB; k++) begin
      h_up.push_back(1'b0);
      h_dn.push_back(1'b0);
    end
  endtask

  // One rising edge of the model, given the raw inputs sampled on that edge.
  task automatic model_edge(input logic u, input logic d);
    logic flip_up;
    logic flip_dn;
    int   gap;
    m_n++;
    m_step = 1'b0;
    case (m_mode)
      M_IDLE: begin
        if (m_deb_up && m_deb_dn) m_mode = M_LOCK;
        else if (m_deb_up || m_deb_dn) begin
          m_step = 1'b1;
          m_ud   = m_deb_dn;
          m_mode = m_deb_dn ? M_DN : M_UP;
          m_last = m_n;
          m_nrep = 0;
        end
      end
      M_UP, M_DN: begin
        if ((m_mode == M_UP) ? m_deb_dn : m_deb_up) m_mode = M_LOCK;
        else if (!((m_mode == M_UP) ? m_deb_up : m_deb_dn)) m_mode = M_IDLE;
        else begin
          gap = (m_nrep == 0) ? RD : RP;
          if (m_n - m_last == gap) begin
            m_step = 1'b1;
            m_last = m_n;
            m_nrep++;
          end
        end
      end
      default: if (!m_deb_up && !m_deb_dn) m_mode = M_IDLE;
    endcase
    // Debounced value flips once the last DEB synchronised samples all
    // disagree with it; h[0] is the newest raw sample, still in flight.
    flip_up = 1'b1;
    flip_dn = 1'b1;
    for (int k = 1; k <= DEB; k++) begin
      if (h_up[k] == m_deb_up) flip_up = 1'b0;
      if (h_dn[k] == m_deb_dn) flip_dn = 1'b0;
    end
    if (flip_up) m_deb_up = ~m_deb_up;
    if (flip_dn) m_deb_dn = ~m_deb_dn;
    h_up.push_front(u);
    h_dn.push_front(d);
    void'(h_up.pop_back());
    void'(h_dn.pop_back());
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({ud, step, held} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_values: got ud/step/held=%b required 000", {ud, step, held});
    end
    do_reset();
    btn_dn = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    n_tests++;
    if ({ud, step, held} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_pre_press: got ud/step/held=%b required 111 after edge 7", {ud, step, held});
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (step !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_step: got %b required 0", step);
    end
    n_tests++;
    if (ud !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_ud: got %b required 0", ud);
    end
    n_tests++;
    if (held !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async_held: got %b required 0", held);
    end
    btn_dn = 1'b0;
  endtask

  task automatic test_single_press();
    int   nsteps = 0;
    int   step_edge = -1;
    int   rise = -1;
    int   fall = -1;
    logic held_prev = 1'b0;
    logic ud_at_step = 1'bx;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      btn_up = (e <= 5);
      tick();
      if (step === 1'b1) begin
        nsteps++;
        step_edge  = e;
        ud_at_step = ud;
      end
      if (held === 1'b1 && !held_prev && rise < 0) rise = e;
      if (held !== 1'b1 && held_prev && fall < 0) fall = e;
      held_prev = (held === 1'b1);
    end
    n_tests++;
    if (nsteps != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d steps required 1", nsteps);
    end
    n_tests++;
    if (step_edge != DEB + 3) begin
      n_fail++;
      $display("FAIL single_latency: got step at edge %0d required %0d", step_edge, DEB + 3);
    end
    n_tests++;
    if (ud_at_step !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ud: got %b required 0", ud_at_step);
    end
    n_tests++;
    if (rise != DEB + 3) begin
      n_fail++;
      $display("FAIL single_held_rise: got edge %0d required %0d", rise, DEB + 3);
    end
    n_tests++;
    if (fall != 6 + DEB + 2) begin
      n_fail++;
      $display("FAIL single_held_fall: got edge %0d required %0d", fall, 6 + DEB + 2);
    end
  endtask

  task automatic test_bounce();
    int nsteps = 0;
    int nheld = 0;
    int nud = 0;
    do_reset();
    for (int e = 1; e <= 50; e++) begin
      btn_dn = (e <= 40) && (((e - 1) % 4) != 3);
      tick();
      if (step !== 1'b0) nsteps++;
      if (held !== 1'b0) nheld++;
      if (ud !== 1'b0) nud++;
    end
    n_tests++;
    if (nsteps != 0) begin
      n_fail++;
      $display("FAIL bounce_steps: got %0d steps required 0", nsteps);
    end
    n_tests++;
    if (nheld != 0) begin
      n_fail++;
      $display("FAIL bounce_held: got held high %0d cycles required 0", nheld);
    end
    n_tests++;
    if (nud != 0) begin
      n_fail++;
      $display("FAIL bounce_ud: got ud high %0d cycles required 0", nud);
    end
  endtask

  task automatic test_auto_repeat();
    int exp_edges[7] = '{7, 23, 31, 39, 47, 55, 63};
    int got[$];
    int bad_ud = 0;
    int fall = -1;
    logic held_prev = 1'b0;
    do_reset();
    for (int e = 1; e <= 80; e++) begin
      btn_dn = (e <= 60);
      tick();
      if (step === 1'b1) begin
        got.push_back(e);
        if (ud !== 1'b1) bad_ud++;
      end
      if (held !== 1'b1 && held_prev && fall < 0) fall = e;
      held_prev = (held === 1'b1);
    end
    n_tests++;
    if (got.size() != 7) begin
      n_fail++;
      $display("FAIL repeat_count: got %0d steps required 7", got.size());
    end
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (i >= got.size() || got[i] != exp_edges[i]) begin
        n_fail++;
        $display("FAIL repeat_edge%0d: got edge %0d required %0d", i,
                 (i < got.size()) ? got[i] : -1, exp_edges[i]);
      end
    end
    n_tests++;
    if (bad_ud != 0) begin
      n_fail++;
      $display("FAIL repeat_ud: got %0d steps with ud!=1 required 0", bad_ud);
    end
    n_tests++;
    if (fall != 61 + DEB + 2) begin
      n_fail++;
      $display("FAIL repeat_held_fall: got edge %0d required %0d", fall, 61 + DEB + 2);
    end
  endtask

  task automatic test_lockout();
    int exp_edges[2] = '{7, 67};
    int got[$];
    int nud = 0;
    int fall = -1;
    logic held_prev = 1'b0;
    do_reset();
    for (int e = 1; e <= 80; e++) begin
      btn_up = (e <= 39) || (e >= 61 && e <= 75);
      btn_dn = (e >= 12) && (e <= 31);
      tick();
      if (step === 1'b1) got.push_back(e);
      if (ud !== 1'b0) nud++;
      if (held !== 1'b1 && held_prev && fall < 0) fall = e;
      held_prev = (held === 1'b1);
    end
    n_tests++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL lockout_count: got %0d steps required 2", got.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (i >= got.size() || got[i] != exp_edges[i]) begin
        n_fail++;
        $display("FAIL lockout_edge%0d: got edge %0d required %0d", i,
                 (i < got.size()) ? got[i] : -1, exp_edges[i]);
      end
    end
    n_tests++;
    if (nud != 0) begin
      n_fail++;
      $display("FAIL lockout_ud: got ud high %0d cycles required 0", nud);
    end
    n_tests++;
    if (fall != 12 + DEB + 2) begin
      n_fail++;
      $display("FAIL lockout_held_fall: got edge %0d required %0d", fall, 12 + DEB + 2);
    end
  endtask

  task automatic test_reset_during_hold();
    int exp_edges[2] = '{7, 27};
    int got[$];
    do_reset();
    btn_up = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (step === 1'b1) got.push_back(e);
    end
    n_tests++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_reset_pre_held: got %b required 1", held);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({ud, step, held} !== 3'b000) begin
      n_fail++;
      $display("FAIL hold_reset_async: got ud/step/held=%b required 000", {ud, step, held});
    end
    #1 reset = 1'b1;
    for (int e = 21; e <= 40; e++) begin
      tick();
      if (step === 1'b1) got.push_back(e);
    end
    n_tests++;
    if (got.size() != 2) begin
      n_fail++;
      $display("FAIL hold_reset_count: got %0d steps required 2", got.size());
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (i >= got.size() || got[i] != exp_edges[i]) begin
        n_fail++;
        $display("FAIL hold_reset_edge%0d: got edge %0d required %0d", i,
                 (i < got.size()) ? got[i] : -1, exp_edges[i]);
      end
    end
    btn_up = 1'b0;
  endtask

  task automatic test_random();
    int   run_up = 0;
    int   run_dn = 0;
    logic v_up = 1'b0;
    logic v_dn = 1'b0;
    do_reset();
    model_reset();
    for (int i = 0; i < 4000; i++) begin
      if (run_up == 0) begin
        v_up   = 1'($urandom_range(0, 1));
        run_up = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 60));
      end
      if (run_dn == 0) begin
        v_dn   = 1'($urandom_range(0, 1));
        run_dn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : int'($urandom_range(6, 60));
      end
      run_up--;
      run_dn--;
      btn_up = v_up;
      btn_dn = v_dn;
      tick();
      model_edge(v_up, v_dn);
      n_tests++;
      if (step !== m_step) begin
        n_fail++;
        $display("FAIL rand_step @%0d: got %b required %b", i, step, m_step);
      end
      n_tests++;
      if (ud !== m_ud) begin
        n_fail++;
        $display("FAIL rand_ud @%0d: got %b required %b", i, ud, m_ud);
      end
      n_tests++;
      if (held !== (m_mode == M_UP || m_mode == M_DN)) begin
        n_fail++;
        $display("FAIL rand_held @%0d: got %b required %b", i, held,
                 (m_mode == M_UP || m_mode == M_DN));
      end
      if (i % 1000 == 999) begin
        #2 reset = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if ({ud, step, held} !== 3'b000) begin
          n_fail++;
          $display("FAIL rand_reset @%0d: got ud/step/held=%b required 000", i, {ud, step, held});
        end
        #1 reset = 1'b1;
      end
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
  endtask

  initial begin
    reset  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    test_reset();
    test_single_press();
    test_bounce();
    test_auto_repeat();
    test_lockout();
    test_reset_during_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_step_ctrl.md
# updown_step_ctrl

Front-end controller for the mod-N up/down counter. It turns two raw push-buttons, UP and DOWN, into the counter's direction input and a one-cycle step pulse. The step pulse gates the counter's clock enable. The block synchronises and debounces each button, and auto-repeats while a button is held. If both buttons are pressed together, stepping is locked out until both are released.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive synchronised cycles an input must differ from its debounced value before the debounced value flips; must be ≥2
- REPEAT_DELAY, 16: cycles from the first step of a hold to the first auto-repeat step; must be ≥2
- REPEAT_PERIOD, 8: cycles between successive auto-repeat steps; must be ≥2

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- btn_up  input  1  raw UP button, asynchronous, active-high
- btn_dn  input  1  raw DOWN button, asynchronous, active-high
- ud  output  1  direction to counter: 0 = up, 1 = down; holds last direction
- step  output  1  one-cycle step pulse, registered
- held  output  1  high while in UP_HELD or DN_HELD

## Operation
- **Synchroniser:** two flops per button, both reset to 0.
- **Debounce, per button:**
  - Counter cleared whenever sync == deb.
  - Counter increments while sync != deb.
  - When sync != deb and the counter equals DEBOUNCE_CYCLES-1, deb flips and the counter clears.
  - A bounce shorter than DEBOUNCE_CYCLES cycles never changes deb.
- **FSM states:** IDLE, UP_HELD, DN_HELD, LOCKOUT. Reset state is IDLE.
- **IDLE:**
  - deb_up & ~deb_dn: step=1, ud=0, load repeat timer for REPEAT_DELAY, go to UP_HELD.
  - deb_dn & ~deb_up: step=1, ud=1, load repeat timer for REPEAT_DELAY, go to DN_HELD.
  - Both high: go to LOCKOUT, no step.
- **UP_HELD:**
  - deb_dn high: go to LOCKOUT, no step. This takes priority over release.
  - Else ~deb_up: go to IDLE.
  - Else the timer counts. On expiry: step=1 and reload for REPEAT_PERIOD.
- **DN_HELD:** mirror of UP_HELD with the buttons swapped; ud stays 1.
- **LOCKOUT:** no steps. Go to IDLE only when deb_up and deb_dn are both 0.
- **ud:** changes only in the cycle a step is issued from IDLE. It is unchanged by LOCKOUT and by release.
- **step:** never high in two consecutive cycles.
- **Timer:** width is clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) + 1. It must not wrap while a button is held.

## Timing
- **Reset values (asynchronous, immediate):** ud=0, step=0, held=0, FSM=IDLE; all synchroniser, debounce and timer registers 0.
- **Reset asserted mid-hold:** step drops immediately, no pending repeat survives, and ud returns to 0. After deassertion a still-pressed button re-debounces and issues a fresh first step.
- **First-step latency:** the raw input is stable high from before edge 1. step is high for exactly one cycle following edge DEBOUNCE_CYCLES+3, i.e. edge 7 at the default.
- **held timing:** held rises on the same edge as the first step. It falls on the edge the FSM leaves the HELD state.
- **Repeat spacing:** the first repeat step comes REPEAT_DELAY cycles after the first step. Subsequent repeats come every REPEAT_PERIOD cycles.
- **Release latency:** DEBOUNCE_CYCLES+3 edges from raw release to the FSM leaving the HELD state. A repeat that falls due within that window is still issued.
- **Simultaneous debounced rise in IDLE:** LOCKOUT, no step, ud unchanged.

## Test plan
- **Reset:** drive reset=0 mid-cycle -> ud=0, step=0, held=0 without waiting for a clock edge.
- **Single press** (defaults, btn_up held 5 cycles from edge 1, then released):
  - Exactly one step, high after edge 7, with ud=0.
  - held=1 from edge 7 until the release is debounced.
- **Bounce:** btn_dn toggling with high pulses of 3 cycles separated by 1-cycle lows for 40 cycles -> no step, ud unchanged.
- **Auto-repeat:** btn_dn held 60 cycles -> steps at edges 7, 23, 31, 39, 47, 55, 63, all with ud=1.
- **Lockout:** btn_up held; btn_dn pressed at edge 12 and held 20 cycles; btn_up released at edge 40 -> no step after the first until both buttons are released and one is pressed again; ud stays 0.
- **Reset during hold:** btn_up held, reset pulsed low at edge 20 -> step and held drop immediately; next step at edge 27, where edge 27 = DEBOUNCE_CYCLES+3 edges after reset release.
